// File: rtl/opctrl_rpath_if.sv
// Handshake bundle for the op-control return path: core-side input, controller-side output, status.
// The DoutParErr member exists only when OPCTRL_RPATH_PARITY_EN is defined.
interface opctrl_rpath_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int LVLW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] Din;
  logic             DinValid;
  logic             DinReady;
  logic [WIDTH-1:0] Dout;
  logic             DoutValid;
  logic             DoutReady;
  logic [LVLW-1:0]  Level;
  logic             Overflow;
`ifdef OPCTRL_RPATH_PARITY_EN
  logic             DoutParErr;

  modport master (output Din, DinValid, DoutReady,
                  input  DinReady, Dout, DoutValid, Level, Overflow, DoutParErr);
  modport slave  (input  Din, DinValid, DoutReady,
                  output DinReady, Dout, DoutValid, Level, Overflow, DoutParErr);
`else
  modport master (output Din, DinValid, DoutReady,
                  input  DinReady, Dout, DoutValid, Level, Overflow);
  modport slave  (input  Din, DinValid, DoutReady,
                  output DinReady, Dout, DoutValid, Level, Overflow);
`endif
endinterface

// File: rtl/opctrl_rpath.sv
// Return datapath: PIPE-1 never-stalling delay stages feeding an elastic FIFO, with credit-style DinReady.
// Define OPCTRL_RPATH_PARITY_EN to carry an even-parity bit per word and expose DoutParErr.
module opctrl_rpath #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 3,
  parameter int DEPTH = 4
) (
  input logic          Clock,
  input logic          Reset,
  opctrl_rpath_if.slave bus
);

`ifdef OPCTRL_RPATH_PARITY_EN
  localparam int PARW = 1;
`else
  localparam int PARW = 0;
`endif
  localparam int SW   = WIDTH + PARW;
  localparam int NSTG = (PIPE > 1) ? PIPE - 1 : 1;
  localparam int PTRW = $clog2(DEPTH);
  localparam int LVLW = $clog2(DEPTH + 1);
  localparam int CW   = $clog2(DEPTH + NSTG + 1) + 1;

  logic [SW-1:0]   stage_data_q [NSTG];
  logic [SW-1:0]   stage_data_d [NSTG];
  logic [NSTG-1:0] stage_vld_q, stage_vld_d;
  logic [SW-1:0]   mem_q [DEPTH];
  logic [SW-1:0]   mem_d [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] level_q, level_d;
  logic            overflow_q, overflow_d;

  logic [SW-1:0]   din_ext;
  logic [SW-1:0]   wr_data;
  logic [SW-1:0]   head;
  logic [CW-1:0]   credit_sum;
  logic            din_ready;
  logic            accept;
  logic            wr_en;
  logic            pop;

`ifdef OPCTRL_RPATH_PARITY_EN
  assign din_ext = {^bus.Din, bus.Din};
`else
  assign din_ext = bus.Din;
`endif

  // Credit counts words already in the FIFO plus those still in the delay stages; pops are not credited.
  always_comb begin
    credit_sum = CW'(level_q);
    for (int i = 0; i < NSTG; i++) begin
      credit_sum = credit_sum + CW'(stage_vld_q[i]);
    end
    din_ready  = (credit_sum < CW'(DEPTH));
    accept     = bus.DinValid && din_ready;
    overflow_d = overflow_q || (bus.DinValid && !din_ready);

    stage_vld_d  = '0;
    stage_data_d = stage_data_q;
    if (PIPE > 1) begin
      stage_vld_d[0]  = accept;
      stage_data_d[0] = din_ext;
      for (int i = 1; i < NSTG; i++) begin
        stage_vld_d[i]  = stage_vld_q[i-1];
        stage_data_d[i] = stage_data_q[i-1];
      end
    end

    if (PIPE == 1) begin
      wr_en   = accept;
      wr_data = din_ext;
    end else begin
      wr_en   = stage_vld_q[NSTG-1];
      wr_data = stage_data_q[NSTG-1];
    end

    pop = (level_q != '0) && bus.DoutReady;

    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
    end
    wr_ptr_d = wr_ptr_q + PTRW'(wr_en);
    rd_ptr_d = rd_ptr_q + PTRW'(pop);
    level_d  = level_q + LVLW'(wr_en) - LVLW'(pop);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stage_vld_q <= '0;
      for (int i = 0; i < NSTG; i++) begin
        stage_data_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      stage_vld_q  <= stage_vld_d;
      stage_data_q <= stage_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked whenever Level is zero.
  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.DinReady  = din_ready;
  assign bus.DoutValid = (level_q != '0);
  assign bus.Dout      = (level_q != '0) ? head[WIDTH-1:0] : '0;
  assign bus.Level     = level_q;
  assign bus.Overflow  = overflow_q;
`ifdef OPCTRL_RPATH_PARITY_EN
  assign bus.DoutParErr = (level_q != '0) && ((^head[WIDTH-1:0]) != head[WIDTH]);
`endif

endmodule

// File: tb/tb_opctrl_rpath.sv
// Directed self-checking bench for opctrl_rpath (WIDTH=32, PIPE=3, DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising Clock edge.
module tb_opctrl_rpath;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  opctrl_rpath_if #(.WIDTH(32), .DEPTH(4)) bus ();

  opctrl_rpath #(.WIDTH(32), .PIPE(3), .DEPTH(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] expq [$];
  logic        rdy;
  logic [31:0] w;
  int          n;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] din, input logic dinValid, input logic doutReady);
    bus.Din       = din;
    bus.DinValid  = dinValid;
    bus.DoutReady = doutReady;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Pop-side scoreboard check for cycles where the bench itself drives DoutReady randomly.
  task automatic checkPop(input string tag, input logic ready);
    if (bus.DoutValid && ready) begin
      if (expq.size() == 0) begin
        checkOutput({tag, "_spurious"}, 32'(bus.DoutValid), 32'd0);
      end else begin
        checkOutput(tag, bus.Dout, expq.pop_front());
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    applyStimulus(32'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_level",    32'(bus.Level),     32'd0);
    checkOutput("rst_valid",    32'(bus.DoutValid), 32'd0);
    checkOutput("rst_dout",     bus.Dout,           32'd0);
    checkOutput("rst_overflow", 32'(bus.Overflow),  32'd0);
    checkOutput("rst_ready",    32'(bus.DinReady),  32'd1);
    Reset = 1'b0;

    // Single word: accepted at edge n, visible from edge n+2, popped at n+3.
    applyStimulus(32'hA5A5_0001, 1'b1, 1'b1);
    tick();
    applyStimulus(32'd0, 1'b0, 1'b1);
    checkOutput("single_valid_n", 32'(bus.DoutValid), 32'd0);
    tick();
    checkOutput("single_valid_n1", 32'(bus.DoutValid), 32'd0);
    tick();
    checkOutput("single_valid_n2", 32'(bus.DoutValid), 32'd1);
    checkOutput("single_dout",     bus.Dout,           32'hA5A5_0001);
    checkOutput("single_level1",   32'(bus.Level),     32'd1);
    tick();
    checkOutput("single_valid_n3", 32'(bus.DoutValid), 32'd0);
    checkOutput("single_level0",   32'(bus.Level),     32'd0);
    checkOutput("single_overflow", 32'(bus.Overflow),  32'd0);

    // Credit fill: four accepts exhaust the credit, the fifth word is dropped.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(32'(i), 1'b1, 1'b0);
      checkOutput("fill_ready", 32'(bus.DinReady), (i <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    applyStimulus(32'd0, 1'b0, 1'b0);
    checkOutput("fill_overflow", 32'(bus.Overflow), 32'd1);
    tick();
    checkOutput("fill_level",       32'(bus.Level),    32'd4);
    checkOutput("fill_ready_full",  32'(bus.DinReady), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(32'd0, 1'b0, 1'b1);
      checkOutput("fill_drain", bus.Dout, 32'(k));
      tick();
    end
    checkOutput("fill_empty_valid", 32'(bus.DoutValid), 32'd0);
    checkOutput("fill_empty_level", 32'(bus.Level),     32'd0);
    checkOutput("fill_sticky",      32'(bus.Overflow),  32'd1);
    Reset = 1'b1;
    applyStimulus(32'd0, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
    checkOutput("fill_rst_overflow", 32'(bus.Overflow), 32'd0);
    checkOutput("fill_rst_ready",    32'(bus.DinReady), 32'd1);

    // Streaming: word c appears in the window after edge c+2 with Level held at 1.
    for (int c = 0; c <= 22; c++) begin
      applyStimulus(32'(c), (c < 20), 1'b1);
      tick();
      if (c >= 2 && c <= 21) begin
        checkOutput("stream_valid", 32'(bus.DoutValid), 32'd1);
        checkOutput("stream_dout",  bus.Dout,           32'(c - 2));
        checkOutput("stream_level", 32'(bus.Level),     32'd1);
        checkOutput("stream_ready", 32'(bus.DinReady),  32'd1);
      end else if (c == 22) begin
        checkOutput("stream_end_valid", 32'(bus.DoutValid), 32'd0);
        checkOutput("stream_end_level", 32'(bus.Level),     32'd0);
      end
    end
    checkOutput("stream_overflow", 32'(bus.Overflow), 32'd0);

    // Simultaneous FIFO write and pop at Level=1.
    applyStimulus(32'h0000_0011, 1'b1, 1'b0);
    tick();
    applyStimulus(32'd0, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(32'h0000_0022, 1'b1, 1'b0);
    tick();
    applyStimulus(32'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(32'd0, 1'b0, 1'b1);
    checkOutput("pp_head_before",  bus.Dout,       32'h0000_0011);
    checkOutput("pp_level_before", 32'(bus.Level), 32'd1);
    tick();
    checkOutput("pp_level_after", 32'(bus.Level),     32'd1);
    checkOutput("pp_head_after",  bus.Dout,           32'h0000_0022);
    checkOutput("pp_valid_after", 32'(bus.DoutValid), 32'd1);
    tick();
    checkOutput("pp_drained", 32'(bus.Level), 32'd0);

    // Pointer wrap: ten rounds of three words with random DoutReady.
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 3; j++) begin
        w   = 32'hC0DE_0000 + 32'(r * 16 + j);
        rdy = 1'($urandom_range(0, 1));
        applyStimulus(w, 1'b1, rdy);
        checkOutput("wrap_ready", 32'(bus.DinReady), 32'd1);
        checkPop("wrap_data", rdy);
        expq.push_back(w);
        tick();
      end
      n = 0;
      while (expq.size() != 0 && n < 40) begin
        rdy = 1'($urandom_range(0, 1));
        applyStimulus(32'd0, 1'b0, rdy);
        checkPop("wrap_data", rdy);
        tick();
        n++;
      end
      checkOutput("wrap_drained", 32'(expq.size()), 32'd0);
      expq.delete();
      checkOutput("wrap_level", 32'(bus.Level), 32'd0);
    end

    // Reset with words both in the FIFO and in the delay stages.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(32'hDEAD_0000 + 32'(k), 1'b1, 1'b0);
      tick();
    end
    checkOutput("mid_pre_level", 32'(bus.Level),    32'd2);
    checkOutput("mid_pre_ready", 32'(bus.DinReady), 32'd0);
    Reset = 1'b1;
    applyStimulus(32'd0, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
    checkOutput("mid_level",    32'(bus.Level),     32'd0);
    checkOutput("mid_valid",    32'(bus.DoutValid), 32'd0);
    checkOutput("mid_dout",     bus.Dout,           32'd0);
    checkOutput("mid_overflow", 32'(bus.Overflow),  32'd0);
    checkOutput("mid_ready",    32'(bus.DinReady),  32'd1);
    applyStimulus(32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("mid_flushed", 32'(bus.DoutValid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
